sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO. It is the same-clock-domain successor of the team's dual-clock FIFO, for buffering inside one domain (AXI channel skid/queue, FPU result queue).
- Generalised in width and depth. Adds selectable read mode (registered or first-word-fall-through), programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags.

---
 rtl/sync_fifo_param.sv | 116 +++++++++++
 tb/tb_sync_fifo_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter bit FWFT       = 1'b0,
    parameter int AFULL_TH   = 14,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wpush,
    input  logic                  rpop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  afull,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] head;
    logic                  push_ok, pop_ok;

    // Status depends on registered pointers/count only.
    assign wfull  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                    (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    assign rempty = (wptr_q == rptr_q);
    assign afull  = (count_q >= AFULL_C);
    assign aempty = (count_q <= AEMPTY_C);

    assign push_ok = wpush & ~wfull;
    assign pop_ok  = rpop & ~rempty;
    assign head    = mem_q[rptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        if (!clear) begin
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop_ok) begin
                rptr_d   = rptr_q + 1'b1;
                rvalid_d = 1'b1;
                rdata_d  = head;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (wpush & wfull);
            udf_d = udf_q | (rpop & rempty);
        end else begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wdata;
    end

    // FWFT presents the head directly; zero while empty keeps the reset value defined.
    assign rdata     = FWFT ? (rempty ? '0 : head) : rdata_q;
    assign rvalid    = FWFT ? ~rempty : rvalid_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered-read instance checked against a queue model and
// read scoreboard, plus a first-word-fall-through instance.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear0 = 1'b0, wpush0 = 1'b0, rpop0 = 1'b0;
    logic [31:0] wdata0 = '0;
    logic [31:0] rdata0;
    logic        rvalid0, wfull0, rempty0, afull0, aempty0, ovf0, udf0;
    logic [4:0]  count0;
    logic        clear1 = 1'b0, wpush1 = 1'b0, rpop1 = 1'b0;
    logic [31:0] wdata1 = '0;
    logic [31:0] rdata1;
    logic        rvalid1, wfull1, rempty1, afull1, aempty1, ovf1, udf1;
    logic [4:0]  count1;

    int checks = 0;
    int failures = 0;

    logic [31:0] m0[$];
    logic [31:0] sb[$];
    logic [31:0] m1[$];
    bit          movf = 0, mudf = 0;
    logic [31:0] last_rd = '0;

    typedef struct {
        int          predrain;
        int          prefill;
        logic [31:0] pfbase;
        logic        push;
        logic [31:0] data;
        logic        pop;
        logic        clr;
        int          ecount;
        logic        eovf;
        logic        eudf;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(1'b0), .AFULL_TH(14), .AEMPTY_TH(2)) dut0 (
        .clk(clk), .rst(rst), .clear(clear0), .wdata(wdata0), .wpush(wpush0), .rpop(rpop0),
        .rdata(rdata0), .rvalid(rvalid0), .wfull(wfull0), .rempty(rempty0), .afull(afull0),
        .aempty(aempty0), .count(count0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(1'b1), .AFULL_TH(14), .AEMPTY_TH(2)) dut1 (
        .clk(clk), .rst(rst), .clear(clear1), .wdata(wdata1), .wpush(wpush1), .rpop(rpop1),
        .rdata(rdata1), .rvalid(rvalid1), .wfull(wfull1), .rempty(rempty1), .afull(afull1),
        .aempty(aempty1), .count(count1), .overflow(ovf1), .underflow(udf1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle0(input logic p, input logic [31:0] d, input logic r, input logic c);
        bit pok, rok;
        logic [31:0] exp;
        pok = p && (m0.size() < 16);
        rok = r && (m0.size() > 0);
        if (c) begin
            m0.delete();
            movf = 0;
            mudf = 0;
        end else begin
            if (p && !pok) movf = 1;
            if (r && !rok) mudf = 1;
            if (rok) sb.push_back(m0.pop_front());
            if (pok) m0.push_back(d);
        end
        wpush0 = p; wdata0 = d; rpop0 = r; clear0 = c;
        @(posedge clk);
        #1;
        wpush0 = 0; rpop0 = 0; clear0 = 0;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk("rvalid", {63'd0, rvalid0}, 64'd1);
            chk("rdata", {32'd0, rdata0}, {32'd0, exp});
            last_rd = exp;
        end else begin
            chk("rvalid_idle", {63'd0, rvalid0}, 64'd0);
            chk("rdata_hold", {32'd0, rdata0}, {32'd0, last_rd});
        end
        chk("count", {59'd0, count0}, 64'(m0.size()));
        chk("wfull", {63'd0, wfull0}, {63'd0, m0.size() == 16});
        chk("rempty", {63'd0, rempty0}, {63'd0, m0.size() == 0});
        chk("afull", {63'd0, afull0}, {63'd0, m0.size() >= 14});
        chk("aempty", {63'd0, aempty0}, {63'd0, m0.size() <= 2});
        chk("overflow", {63'd0, ovf0}, {63'd0, movf});
        chk("underflow", {63'd0, udf0}, {63'd0, mudf});
    endtask

    task automatic cycle1(input logic p, input logic [31:0] d, input logic r);
        bit pok, rok;
        pok = p && (m1.size() < 16);
        rok = r && (m1.size() > 0);
        if (rok) void'(m1.pop_front());
        if (pok) m1.push_back(d);
        wpush1 = p; wdata1 = d; rpop1 = r;
        @(posedge clk);
        #1;
        wpush1 = 0; rpop1 = 0;
        chk("f_rvalid", {63'd0, rvalid1}, {63'd0, m1.size() > 0});
        chk("f_rempty", {63'd0, rempty1}, {63'd0, m1.size() == 0});
        chk("f_count", {59'd0, count1}, 64'(m1.size()));
        if (m1.size() > 0) chk("f_rdata", {32'd0, rdata1}, {32'd0, m1[0]});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] k;
        vecs[0] = '{0, 16, 32'h20, 1'b1, 32'hAA, 1'b1, 1'b0, 15, 1'b1, 1'b0};
        vecs[1] = '{15, 0, 32'h0, 1'b1, 32'h55, 1'b1, 1'b0, 1, 1'b1, 1'b1};
        vecs[2] = '{0, 0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b1, 1'b1};
        vecs[3] = '{0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[4] = '{0, 8, 32'h40, 1'b1, 32'h99, 1'b1, 1'b0, 8, 1'b0, 1'b0};
        vecs[5] = '{0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0};

        #1 rst = 1'b0;
        #2;
        chk("rst_count", {59'd0, count0}, 64'd0);
        chk("rst_rempty", {63'd0, rempty0}, 64'd1);
        chk("rst_wfull", {63'd0, wfull0}, 64'd0);
        chk("rst_aempty", {63'd0, aempty0}, 64'd1);
        chk("rst_afull", {63'd0, afull0}, 64'd0);
        chk("rst_ovf", {63'd0, ovf0}, 64'd0);
        chk("rst_udf", {63'd0, udf0}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid0}, 64'd0);
        chk("rst_rdata", {32'd0, rdata0}, 64'd0);
        chk("rst_f_rvalid", {63'd0, rvalid1}, 64'd0);
        chk("rst_f_rdata", {32'd0, rdata1}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Fill and drain, then underflow, overflow and clear.
        for (int i = 0; i < 16; i++) cycle0(1'b1, 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle0(1'b0, 32'h0, 1'b1, 1'b0);
        cycle0(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cycle0(1'b1, 32'(i), 1'b0, 1'b0);
        cycle0(1'b1, 32'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle0(1'b0, 32'h0, 1'b1, 1'b0);
        chk("last_entry", {32'd0, last_rd}, 64'h0F);
        cycle0(1'b0, 32'h0, 1'b0, 1'b1);

        // Simultaneous push/pop corners from the vector table.
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < vecs[i].predrain; j++) cycle0(1'b0, 32'h0, 1'b1, 1'b0);
            for (int j = 0; j < vecs[i].prefill; j++) cycle0(1'b1, vecs[i].pfbase + 32'(j), 1'b0, 1'b0);
            cycle0(vecs[i].push, vecs[i].data, vecs[i].pop, vecs[i].clr);
            chk($sformatf("vec%0d_count", i), {59'd0, count0}, 64'(vecs[i].ecount));
            chk($sformatf("vec%0d_ovf", i), {63'd0, ovf0}, {63'd0, vecs[i].eovf});
            chk($sformatf("vec%0d_udf", i), {63'd0, udf0}, {63'd0, vecs[i].eudf});
        end

        // Streaming across several pointer wraps at occupancy 3.
        k = 32'h100;
        for (int i = 0; i < 3; i++) begin cycle0(1'b1, k, 1'b0, 1'b0); k++; end
        for (int i = 0; i < 40; i++) begin
            cycle0(1'b1, k, 1'b1, 1'b0);
            k++;
            chk("stream_aempty", {63'd0, aempty0}, 64'd0);
            chk("stream_order", {32'd0, rdata0}, {32'd0, k - 32'd4});
        end
        for (int i = 0; i < 3; i++) cycle0(1'b0, 32'h0, 1'b1, 1'b0);

        // First-word-fall-through instance.
        cycle1(1'b1, 32'h11, 1'b0);
        chk("fwft_first", {32'd0, rdata1}, 64'h11);
        chk("fwft_first_valid", {63'd0, rvalid1}, 64'd1);
        cycle1(1'b0, 32'h0, 1'b0);
        cycle1(1'b0, 32'h0, 1'b1);
        chk("fwft_empty_after_pop", {63'd0, rempty1}, 64'd1);
        cycle1(1'b1, 32'h22, 1'b0);
        cycle1(1'b1, 32'h33, 1'b0);
        chk("fwft_head", {32'd0, rdata1}, 64'h22);
        cycle1(1'b0, 32'h0, 1'b1);
        chk("fwft_advance", {32'd0, rdata1}, 64'h33);

        // Asynchronous reset between edges with count at 9.
        for (int i = 0; i < 10; i++) cycle0(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        cycle0(1'b0, 32'h0, 1'b1, 1'b0);
        chk("pre_reset_count", {59'd0, count0}, 64'd9);
        #2 rst = 1'b0;
        #1;
        chk("async_count", {59'd0, count0}, 64'd0);
        chk("async_rempty", {63'd0, rempty0}, 64'd1);
        chk("async_rvalid", {63'd0, rvalid0}, 64'd0);
        chk("async_rdata", {32'd0, rdata0}, 64'd0);
        m0.delete(); sb.delete(); m1.delete();
        movf = 0; mudf = 0; last_rd = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        cycle0(1'b1, 32'h77, 1'b0, 1'b0);
        cycle0(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_reset_data", {32'd0, rdata0}, 64'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
